// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction fetch unit: FSM encoding, default
// parameters and the fetch-buffer entry type.
package fetch_pkg;

    localparam logic [0:0] RUN       = 1'b0;
    localparam logic [0:0] MISS_WAIT = 1'b1;

    localparam logic [31:0] DEFAULT_RESET_PC   = 32'h0000_0000;
    localparam int          DEFAULT_FIFO_DEPTH = 4;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_entry_t;

    function automatic logic [31:0] align_pc(input logic [31:0] pc);
        return {pc[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous fetch buffer holding {pc, instr} entries; flush empties it in
// one cycle and a push into a full buffer is legal when a pop happens alongside.
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter  int DEPTH = DEFAULT_FIFO_DEPTH,
    localparam int AW    = $clog2(DEPTH),
    localparam int CW    = AW + 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          push_i,
    input  logic          pop_i,
    input  logic          flush_i,
    input  fetch_entry_t  wdata_i,
    output fetch_entry_t  rdata_o,
    output logic [CW-1:0] count_o,
    output logic          full_o,
    output logic          empty_o
);

    fetch_entry_t  mem_q [DEPTH];
    logic [AW-1:0] wptr_q;
    logic [AW-1:0] rptr_q;
    logic [CW-1:0] count_q;
    logic          do_push;
    logic          do_pop;

    assign full_o  = (count_q == CW'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign rdata_o = mem_q[rptr_q];

    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (reset || flush_i) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            if (do_push) wptr_q <= wptr_q + 1'b1;
            if (do_pop)  rptr_q <= rptr_q + 1'b1;
            count_q <= count_q + CW'(do_push) - CW'(do_pop);
        end
    end

    // NOTE: storage is not reset; count_q gates visibility of every entry.
    always_ff @(posedge clk) begin
        if (do_push && !reset && !flush_i) begin
            mem_q[wptr_q] <= wdata_i;
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch unit: PC sequencing, miss tracking FSM and a decode-side
// buffer. Define FETCH_PERF_CNT_EN to add the miss/fetch performance counters.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = DEFAULT_RESET_PC,
    parameter int          FIFO_DEPTH = DEFAULT_FIFO_DEPTH
) (
    input  logic        clk,
    input  logic        reset,
    output logic [31:0] address,
    input  logic [31:0] instruction,
    input  logic        cache_miss,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_instr,
    output logic [31:0] out_pc,
    output logic        miss_stall
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0] miss_cycles,
    output logic [31:0] fetched_count
`endif
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    logic [31:0]   pc_q;
    logic [31:0]   pc_d;
    logic [0:0]    state_q;
    logic [0:0]    state_d;
    logic          accept;
    logic          pop;
    fetch_entry_t  push_entry;
    fetch_entry_t  head_entry;
    logic [CW-1:0] fifo_count;
    logic          fifo_full;
    logic          fifo_empty;

    assign address    = pc_q;
    assign out_valid  = !fifo_empty && !reset;
    assign miss_stall = (state_q == MISS_WAIT) && !reset;
    assign out_instr  = head_entry.instr;
    assign out_pc     = head_entry.pc;

    assign pop    = out_valid && out_ready;
    assign accept = !cache_miss && !redirect_valid && ((fifo_count < CW'(FIFO_DEPTH)) || pop);

    assign push_entry.pc    = pc_q;
    assign push_entry.instr = instruction;

    // Redirect flushes the buffer and suppresses both the push and the pop.
    fetch_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .push_i  (accept),
        .pop_i   (pop && !redirect_valid),
        .flush_i (redirect_valid),
        .wdata_i (push_entry),
        .rdata_o (head_entry),
        .count_o (fifo_count),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    // NOTE: next-state logic is combinational and uses blocking assignments
    // after a full set of defaults, so no latches can be inferred.
    always_comb begin
        pc_d    = pc_q;
        state_d = state_q;
        if (redirect_valid) begin
            pc_d    = align_pc(redirect_pc);
            state_d = RUN;
        end else begin
            if (accept) pc_d = pc_q + 32'd4;
            if (state_q == RUN) begin
                if (cache_miss) state_d = MISS_WAIT;
            end else begin
                if (!cache_miss) state_d = RUN;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q    <= align_pc(RESET_PC);
            state_q <= RUN;
        end else begin
            pc_q    <= pc_d;
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            assert (fifo_full == (fifo_count == CW'(FIFO_DEPTH)));
        end
    end

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] miss_cycles_q;
    logic [31:0] fetched_count_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            miss_cycles_q   <= '0;
            fetched_count_q <= '0;
        end else begin
            if ((state_q == MISS_WAIT) && (miss_cycles_q != '1)) begin
                miss_cycles_q <= miss_cycles_q + 32'd1;
            end
            if (accept && (fetched_count_q != '1)) begin
                fetched_count_q <= fetched_count_q + 32'd1;
            end
        end
    end

    assign miss_cycles   = miss_cycles_q;
    assign fetched_count = fetched_count_q;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Directed testbench for fetch_unit; the cache returns address ^ 32'hDEAD_0000.
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] address;
    logic [31:0] instruction;
    logic        cache_miss;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic [31:0] out_pc;
    logic        miss_stall;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0] miss_cycles;
    logic [31:0] fetched_count;
`endif

    int passed = 0;
    int total  = 0;

    always #5 clk = ~clk;

    assign instruction = address ^ 32'hDEAD_0000;

    fetch_unit dut (
        .clk            (clk),
        .reset          (reset),
        .address        (address),
        .instruction    (instruction),
        .cache_miss     (cache_miss),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_instr      (out_instr),
        .out_pc         (out_pc),
        .miss_stall     (miss_stall)
`ifdef FETCH_PERF_CNT_EN
        ,
        .miss_cycles    (miss_cycles),
        .fetched_count  (fetched_count)
`endif
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic redirect_to(input logic [31:0] target);
        redirect_valid = 1'b1;
        redirect_pc    = target;
        tick();
        redirect_valid = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; cache_miss = 1'b0; out_ready = 1'b1;
        redirect_valid = 1'b1; redirect_pc = 32'h0000_0300;
        tick(); tick();
        redirect_valid = 1'b0;
        total++; if (address !== 32'h0) $display("FAIL reset_addr: got %h expected %h", address, 32'h0); else passed++;
        total++; if (out_valid !== 1'b0) $display("FAIL reset_valid: got %b expected 0", out_valid); else passed++;
        total++; if (miss_stall !== 1'b0) $display("FAIL reset_stall: got %b expected 0", miss_stall); else passed++;
    endtask

    task automatic test_sequential();
        reset = 1'b0;
        tick();
        total++; if (out_valid !== 1'b1) $display("FAIL seq_valid: got %b expected 1", out_valid); else passed++;
        total++; if (out_pc !== 32'h0) $display("FAIL seq_pc0: got %h expected %h", out_pc, 32'h0); else passed++;
        total++; if (out_instr !== 32'hDEAD_0000) $display("FAIL seq_instr0: got %h expected %h", out_instr, 32'hDEAD_0000); else passed++;
        total++; if (address !== 32'h4) $display("FAIL seq_addr4: got %h expected %h", address, 32'h4); else passed++;
        tick();
        total++; if (out_pc !== 32'h4) $display("FAIL seq_pc4: got %h expected %h", out_pc, 32'h4); else passed++;
        total++; if (address !== 32'h8) $display("FAIL seq_addr8: got %h expected %h", address, 32'h8); else passed++;
        tick();
        total++; if (out_instr !== 32'hDEAD_0008) $display("FAIL seq_instr8: got %h expected %h", out_instr, 32'hDEAD_0008); else passed++;
    endtask

    task automatic test_miss();
        redirect_to(32'h0000_0010);
        total++; if (address !== 32'h10) $display("FAIL miss_redir_addr: got %h expected %h", address, 32'h10); else passed++;
        cache_miss = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            total++; if (miss_stall !== 1'b1) $display("FAIL miss_stall_%0d: got %b expected 1", i, miss_stall); else passed++;
            total++; if (address !== 32'h10) $display("FAIL miss_hold_%0d: got %h expected %h", i, address, 32'h10); else passed++;
        end
        cache_miss = 1'b0;
        tick();
        total++; if (miss_stall !== 1'b0) $display("FAIL miss_exit: got %b expected 0", miss_stall); else passed++;
        total++; if (address !== 32'h14) $display("FAIL miss_next_addr: got %h expected %h", address, 32'h14); else passed++;
        total++; if (out_pc !== 32'h10) $display("FAIL miss_out_pc: got %h expected %h", out_pc, 32'h10); else passed++;
    endtask

    task automatic test_backpressure();
        out_ready = 1'b0;
        redirect_to(32'h0000_0040);
        total++; if (out_valid !== 1'b0) $display("FAIL bp_flush: got %b expected 0", out_valid); else passed++;
        repeat (6) tick();
        total++; if (address !== 32'h50) $display("FAIL bp_full_addr: got %h expected %h", address, 32'h50); else passed++;
        total++; if (out_pc !== 32'h40) $display("FAIL bp_stable_pc: got %h expected %h", out_pc, 32'h40); else passed++;
        total++; if (out_instr !== 32'hDEAD_0040) $display("FAIL bp_stable_instr: got %h expected %h", out_instr, 32'hDEAD_0040); else passed++;
        out_ready = 1'b1;
        tick();
        total++; if (out_pc !== 32'h44) $display("FAIL bp_pp1_pc: got %h expected %h", out_pc, 32'h44); else passed++;
        total++; if (address !== 32'h54) $display("FAIL bp_pp1_addr: got %h expected %h", address, 32'h54); else passed++;
        tick();
        total++; if (address !== 32'h58) $display("FAIL bp_pp2_addr: got %h expected %h", address, 32'h58); else passed++;
        cache_miss = 1'b1;
        for (int i = 0; i < 4; i++) begin
            logic [31:0] exp_pc;
            exp_pc = 32'h48 + 32'(i) * 32'd4;
            total++; if (out_valid !== 1'b1 || out_pc !== exp_pc) $display("FAIL bp_drain_%0d: got valid=%b pc=%h expected valid=1 pc=%h", i, out_valid, out_pc, exp_pc); else passed++;
            tick();
        end
        total++; if (out_valid !== 1'b0) $display("FAIL bp_empty: got %b expected 0", out_valid); else passed++;
        cache_miss = 1'b0;
    endtask

    task automatic test_redirect();
        out_ready = 1'b1;
        redirect_to(32'h0000_0080);
        out_ready = 1'b0;
        repeat (3) tick();
        total++; if (address !== 32'h8C) $display("FAIL rd_pre_addr: got %h expected %h", address, 32'h8C); else passed++;
        redirect_to(32'h0000_0103);
        total++; if (out_valid !== 1'b0) $display("FAIL rd_flush: got %b expected 0", out_valid); else passed++;
        total++; if (address !== 32'h100) $display("FAIL rd_align: got %h expected %h", address, 32'h100); else passed++;
        out_ready = 1'b1;
        tick();
        total++; if (out_pc !== 32'h100) $display("FAIL rd_out_pc: got %h expected %h", out_pc, 32'h100); else passed++;
        total++; if (out_instr !== 32'hDEAD_0100) $display("FAIL rd_out_instr: got %h expected %h", out_instr, 32'hDEAD_0100); else passed++;
    endtask

    task automatic test_redirect_miss();
        redirect_to(32'h0000_0010);
        cache_miss = 1'b1;
        tick();
        total++; if (miss_stall !== 1'b1) $display("FAIL rm_stall: got %b expected 1", miss_stall); else passed++;
        redirect_to(32'h0000_0200);
        total++; if (miss_stall !== 1'b0) $display("FAIL rm_run: got %b expected 0", miss_stall); else passed++;
        total++; if (address !== 32'h200) $display("FAIL rm_addr: got %h expected %h", address, 32'h200); else passed++;
        total++; if (out_valid !== 1'b0) $display("FAIL rm_empty: got %b expected 0", out_valid); else passed++;
        cache_miss = 1'b0;
        tick();
        total++; if (out_pc !== 32'h200) $display("FAIL rm_first_pc: got %h expected %h", out_pc, 32'h200); else passed++;
        tick();
        total++; if (out_pc !== 32'h204) $display("FAIL rm_second_pc: got %h expected %h", out_pc, 32'h204); else passed++;
    endtask

    task automatic test_wrap();
        redirect_to(32'hFFFF_FFFC);
        total++; if (address !== 32'hFFFF_FFFC) $display("FAIL wrap_top: got %h expected %h", address, 32'hFFFF_FFFC); else passed++;
        tick();
        total++; if (address !== 32'h0) $display("FAIL wrap_addr: got %h expected %h", address, 32'h0); else passed++;
        total++; if (out_pc !== 32'hFFFF_FFFC) $display("FAIL wrap_out_pc: got %h expected %h", out_pc, 32'hFFFF_FFFC); else passed++;
        total++; if (out_instr !== 32'h2152_FFFC) $display("FAIL wrap_instr: got %h expected %h", out_instr, 32'h2152_FFFC); else passed++;
    endtask

    task automatic test_reset_mid_miss();
        redirect_to(32'h0000_0010);
        cache_miss = 1'b1;
        tick();
        reset = 1'b1;
        #1;
        total++; if (miss_stall !== 1'b0) $display("FAIL rmm_stall_gate: got %b expected 0", miss_stall); else passed++;
        total++; if (out_valid !== 1'b0) $display("FAIL rmm_valid_gate: got %b expected 0", out_valid); else passed++;
        tick();
        total++; if (address !== 32'h0) $display("FAIL rmm_addr: got %h expected %h", address, 32'h0); else passed++;
        reset = 1'b0;
        cache_miss = 1'b0;
        tick();
        total++; if (out_pc !== 32'h0) $display("FAIL rmm_out_pc: got %h expected %h", out_pc, 32'h0); else passed++;
        total++; if (address !== 32'h4) $display("FAIL rmm_next_addr: got %h expected %h", address, 32'h4); else passed++;
    endtask

    initial begin
        reset = 1'b1; cache_miss = 1'b0; out_ready = 1'b1;
        redirect_valid = 1'b0; redirect_pc = 32'h0;
        test_reset();
        test_sequential();
        test_miss();
        test_backpressure();
        test_redirect();
        test_redirect_miss();
        test_wrap();
        test_reset_mid_miss();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
